// File: rtl/rival_spawn_scheduler.sv
// Rival car spawn sequencer: round-robin slot choice, lane pick
// without repeats, frame-counted spawn gaps, speed ramp, crash halt.
module rival_spawn_scheduler #(
    parameter int          NUM_RIVALS     = 3,
    parameter int          NUM_LANES      = 3,
    parameter int          LANE_X0        = 200,
    parameter int          LANE_PITCH     = 80,
    parameter int          MIN_GAP_FRAMES = 30,
    parameter logic [7:0]  GAP_RAND_MASK  = 8'h1F,
    parameter int          LEVEL_FRAMES   = 600,
    parameter int          INIT_SPEED     = 1,
    parameter int          MAX_SPEED      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_end,
    input  logic [7:0]            rnd,
    input  logic [NUM_RIVALS-1:0] slot_busy,
    input  logic                  collide_with_rival,
    input  logic                  restart,
    output logic [NUM_RIVALS-1:0] spawn,
    output logic [9:0]            spawn_x,
    output logic [3:0]            scroll_speed,
    output logic                  game_over
);

    localparam int LW = $clog2(LEVEL_FRAMES) + 1;

    typedef enum logic [1:0] {
        S_WAIT,
        S_PICK,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t                r_state;
    logic [8:0]            r_gap;
    logic [LW-1:0]         r_level;
    logic [1:0]            r_rr;
    logic [1:0]            r_last;
    logic [1:0]            r_slot;
    logic [1:0]            r_lane;
    logic [NUM_RIVALS-1:0] r_spawn;
    logic [9:0]            r_x;
    logic [3:0]            r_speed;
    logic                  r_over;

    logic [2*NUM_RIVALS-1:0] w_busy2;
    logic [NUM_RIVALS-1:0]   w_rot;
    logic                    w_found;
    logic [1:0]              w_off;
    logic [2:0]              w_sum;
    logic [1:0]              w_slot;
    logic [1:0]              w_cand;
    logic [1:0]              w_lane;
    logic [1:0]              w_rr_nxt;
    logic [3:0]              w_speed_up;
    logic                    w_lvl_last;
    logic [9:0]              w_x;
    logic [8:0]              w_gap_load;
    logic [NUM_RIVALS-1:0]   w_onehot;

    // Rotate busy flags so bit 0 is the round-robin pointer slot.
    assign w_busy2 = {slot_busy, slot_busy};
    assign w_rot   = NUM_RIVALS'(w_busy2 >> r_rr);

    // First idle slot at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_off   = 2'd0;
        for (int k = NUM_RIVALS - 1; k >= 0; k--) begin
            if (!w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 2'(k);
            end
        end
        w_sum = {1'b0, r_rr} + {1'b0, w_off};
        if (w_sum >= 3'(NUM_RIVALS)) begin
            w_sum = w_sum - 3'(NUM_RIVALS);
        end
        w_slot = w_sum[1:0];
    end

    // Lane from the random byte, bumped to the next lane on a repeat.
    always_comb begin
        w_cand = rnd[1:0];
        if ({1'b0, w_cand} >= 3'(NUM_LANES)) begin
            w_cand = w_cand - 2'(NUM_LANES);
        end
        w_lane = w_cand;
        if (w_cand == r_last) begin
            w_lane = (w_cand == 2'(NUM_LANES - 1)) ? 2'd0 : w_cand + 2'd1;
        end
    end

    assign w_rr_nxt   = (r_slot == 2'(NUM_RIVALS - 1)) ? 2'd0 : r_slot + 2'd1;
    assign w_speed_up = (r_speed >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED)
                                                   : r_speed + 4'd1;
    assign w_lvl_last = (r_level == LW'(LEVEL_FRAMES - 1));
    assign w_x        = 10'(LANE_X0 + int'(r_lane) * LANE_PITCH);
    assign w_gap_load = 9'(MIN_GAP_FRAMES) + {1'b0, rnd & GAP_RAND_MASK};
    assign w_onehot   = {{(NUM_RIVALS-1){1'b0}}, 1'b1} << r_slot;

    // Scheduler FSM; r_speed is the visible speed and reads 0 in HALT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_WAIT;
            r_gap   <= 9'(MIN_GAP_FRAMES);
            r_level <= '0;
            r_rr    <= 2'd0;
            r_last  <= 2'(NUM_LANES - 1);
            r_slot  <= 2'd0;
            r_lane  <= 2'd0;
            r_spawn <= '0;
            r_x     <= 10'(LANE_X0);
            r_speed <= 4'(INIT_SPEED);
            r_over  <= 1'b0;
        end else begin
            r_spawn <= '0;
            if (r_state != S_HALT && collide_with_rival) begin
                r_state <= S_HALT;
                r_speed <= 4'd0;
                r_over  <= 1'b1;
            end else begin
                if (r_state != S_HALT && frame_end) begin
                    if (w_lvl_last) begin
                        r_level <= '0;
                        r_speed <= w_speed_up;
                    end else begin
                        r_level <= r_level + 1'b1;
                    end
                end
                unique case (r_state)
                    S_WAIT: begin
                        if (r_gap == 9'd0) begin
                            r_state <= S_PICK;
                        end else if (frame_end) begin
                            r_gap <= r_gap - 9'd1;
                        end
                    end
                    S_PICK: begin
                        if (!w_found) begin
                            r_gap   <= 9'd1;
                            r_state <= S_WAIT;
                        end else begin
                            r_slot  <= w_slot;
                            r_lane  <= w_lane;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_spawn <= w_onehot;
                        r_x     <= w_x;
                        r_rr    <= w_rr_nxt;
                        r_last  <= r_lane;
                        r_gap   <= w_gap_load;
                        r_state <= S_WAIT;
                    end
                    S_HALT: begin
                        if (restart) begin
                            r_state <= S_WAIT;
                            r_gap   <= 9'(MIN_GAP_FRAMES);
                            r_level <= '0;
                            r_speed <= 4'(INIT_SPEED);
                            r_over  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign spawn        = r_spawn;
    assign spawn_x      = r_x;
    assign scroll_speed = r_speed;
    assign game_over    = r_over;

endmodule

// File: tb/tb_rival_spawn_scheduler.sv
// Bench for rival_spawn_scheduler: expected spawns are queued as
// stimulus is set up and matched against each observed strobe.
module tb_rival_spawn_scheduler;

    logic       clk;
    logic       reset;
    logic       frame_end;
    logic [7:0] rnd;
    logic [2:0] slot_busy;
    logic       collide_with_rival;
    logic       restart;
    logic [2:0] spawn;
    logic [9:0] spawn_x;
    logic [3:0] scroll_speed;
    logic       game_over;

    typedef struct {
        logic [2:0] sp;
        logic [9:0] x;
    } exp_t;

    exp_t sb[$];

    int   n_total = 0;
    int   n_bad   = 0;
    int   cycles  = 0;
    int   frames  = 0;
    int   fe_cyc  = 0;
    int   lat     = 0;
    int   nf      = 0;
    bit   got     = 0;
    logic [2:0] prev_sp = '0;

    rival_spawn_scheduler #(
        .NUM_RIVALS    (3),
        .NUM_LANES     (3),
        .LANE_X0       (200),
        .LANE_PITCH    (80),
        .MIN_GAP_FRAMES(2),
        .GAP_RAND_MASK (8'h00),
        .LEVEL_FRAMES  (4),
        .INIT_SPEED    (1),
        .MAX_SPEED     (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_end         (frame_end),
        .rnd               (rnd),
        .slot_busy         (slot_busy),
        .collide_with_rival(collide_with_rival),
        .restart           (restart),
        .spawn             (spawn),
        .spawn_x           (spawn_x),
        .scroll_speed      (scroll_speed),
        .game_over         (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got_v, input int exp_v);
        n_total++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got_v, exp_v);
        end
    endtask

    task automatic push(input logic [2:0] sp, input int x);
        exp_t e;
        e.sp = sp;
        e.x  = 10'(x);
        sb.push_back(e);
    endtask

    // Called #1 after every posedge; matches any strobe against the queue.
    task automatic observe();
        exp_t e;
        if (prev_sp != 3'b000) chk("pulse_width", int'(spawn), 0);
        if (spawn != 3'b000) begin
            chk("onehot", $countones(spawn), 1);
            if (sb.size() == 0) begin
                chk("unexpected_spawn", int'(spawn), 0);
            end else begin
                e = sb.pop_front();
                chk("spawn_slot", int'(spawn), int'(e.sp));
                chk("spawn_x", int'(spawn_x), int'(e.x));
            end
            got = 1;
            lat = cycles - fe_cyc;
        end
        prev_sp = spawn;
    endtask

    task automatic cyc(input bit fe);
        frame_end = fe;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
        cycles++;
        if (fe) begin
            frames++;
            fe_cyc = cycles;
        end
        observe();
    endtask

    // One video frame: a frame_end cycle followed by three idle cycles.
    task automatic frame();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
    endtask

    task automatic run_until_spawn(input int maxf, output int n);
        got = 0;
        n = 0;
        while (!got && n < maxf) begin
            frame();
            n++;
        end
        if (!got) chk("spawn_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        frame_end = 1'b0;
        rnd = 8'h00;
        slot_busy = 3'b000;
        collide_with_rival = 1'b0;
        restart = 1'b0;

        // Reset state
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        chk("rst_spawn", int'(spawn), 0);
        chk("rst_x", int'(spawn_x), 200);
        chk("rst_speed", int'(scroll_speed), 1);
        chk("rst_over", int'(game_over), 0);
        reset = 1'b1;

        // First spawn: last_lane=2, rnd=0 -> lane 0, slot 0.
        // Strobe lands 3 edges after the expiring frame_end:
        // WAIT->PICK, PICK->ISSUE, ISSUE->registered strobe.
        push(3'b001, 200);
        run_until_spawn(5, nf);
        chk("first_frames", nf, 2);
        chk("first_lat", lat, 3);
        chk("first_speed", int'(scroll_speed), 1);

        // Rotation; rnd=0 alternates lanes 1,0,1 due to no-repeat rule.
        push(3'b010, 280);
        run_until_spawn(5, nf);
        chk("rot1_gap", nf, 2);
        push(3'b100, 200);
        run_until_spawn(5, nf);
        chk("rot2_gap", nf, 2);
        push(3'b001, 280);
        run_until_spawn(5, nf);
        chk("rot3_gap", nf, 2);

        // rr_ptr=1 with slot 1 busy -> slot 2; last lane 1 -> lane 0.
        slot_busy = 3'b010;
        push(3'b100, 200);
        run_until_spawn(5, nf);
        chk("skip_gap", nf, 2);

        // All busy: no spawn over several frames.
        slot_busy = 3'b111;
        got = 0;
        for (int i = 0; i < 5; i++) frame();
        chk("full_nospawn", int'(got), 0);

        // Slot 2 frees up; rr_ptr=0 -> search 0,1,2 -> slot 2, lane 1.
        slot_busy = 3'b011;
        push(3'b100, 280);
        run_until_spawn(3, nf);
        chk("full_retry", nf, 1);
        chk("retry_lat", lat, 3);

        // Lane rule with rnd=3 (cand 0) then rnd=2.
        slot_busy = 3'b000;
        rnd = 8'h03;
        push(3'b001, 200);
        run_until_spawn(5, nf);
        push(3'b010, 280);
        run_until_spawn(5, nf);
        rnd = 8'h02;
        push(3'b100, 360);
        run_until_spawn(5, nf);
        push(3'b001, 200);
        run_until_spawn(5, nf);
        chk("lane_gap", nf, 2);

        // Speed ramp: 1 for frames 1..3, 2 for 4..7, 3 from 8 on.
        do_reset();
        slot_busy = 3'b111;
        rnd = 8'h00;
        for (int f = 1; f <= 13; f++) begin
            frame();
            chk($sformatf("speed_f%0d", f), int'(scroll_speed),
                (f < 4) ? 1 : ((f < 8) ? 2 : 3));
        end

        // Collision while in ISSUE suppresses the strobe.
        do_reset();
        slot_busy = 3'b000;
        frame();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        collide_with_rival = 1'b1;
        cyc(1'b0);
        collide_with_rival = 1'b0;
        chk("col_spawn", int'(spawn), 0);
        chk("col_over", int'(game_over), 1);
        chk("col_speed", int'(scroll_speed), 0);
        got = 0;
        for (int i = 0; i < 3; i++) frame();
        chk("halt_nospawn", int'(got), 0);
        chk("halt_over", int'(game_over), 1);

        // Restart: rr_ptr 0 and last_lane 2 kept; rnd=1 -> lane 1.
        restart = 1'b1;
        cyc(1'b0);
        restart = 1'b0;
        chk("rs_over", int'(game_over), 0);
        chk("rs_speed", int'(scroll_speed), 1);
        rnd = 8'h01;
        push(3'b001, 280);
        run_until_spawn(5, nf);
        chk("rs_frames", nf, 2);

        // Collide in WAIT, then reset out of HALT.
        collide_with_rival = 1'b1;
        cyc(1'b0);
        collide_with_rival = 1'b0;
        chk("col2_over", int'(game_over), 1);
        reset = 1'b0;
        cyc(1'b0);
        reset = 1'b1;
        chk("hrst_over", int'(game_over), 0);
        chk("hrst_speed", int'(scroll_speed), 1);
        chk("hrst_x", int'(spawn_x), 200);
        chk("hrst_spawn", int'(spawn), 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
